// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU sequencer.
//   MODE_*    : alu_mode encodings driven to the external combinational ALU
//   state_t   : sequencer FSM states
//   NIB_*     : LSB position of each operation's nibble inside res_out
package alu_pkg;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;
  localparam logic [1:0] MODE_AND = 2'd3;

  localparam int NIB_W   = 4;
  localparam int NIB_ADD = 0;
  localparam int NIB_SUB = 4;
  localparam int NIB_XOR = 8;
  localparam int NIB_AND = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_check.sv
// alu_seq_check -- reference model for the external ALU. Compares every
// nibble captured during ISSUE against the value computed here and raises a
// sticky error flag on any difference.
//   clk, rst_n        : clock, async active-low reset
//   start             : request accepted this cycle, clears err
//   cap_en            : a nibble is captured at the end of this cycle
//   a, b, c_in, mode  : operands and mode currently driven to the ALU
//   result, c_out     : ALU response being captured
//   err               : sticky mismatch flag
module alu_seq_check
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cap_en,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       c_in,
  input  logic [1:0] mode,
  input  logic [2:0] result,
  input  logic       c_out,
  output logic       err
);

  logic [3:0] expected;

  always_comb begin
    expected = 4'd0;
    case (mode)
      MODE_ADD: expected = {1'b0, a} + {1'b0, b} + {3'b000, c_in};
      // the ALU supplies its own carry-in of 1 for subtraction
      MODE_SUB: expected = {1'b0, a} + {1'b0, ~b} + 4'd1;
      MODE_XOR: expected = {1'b0, a ^ b};
      default:  expected = {1'b0, a & b};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start) begin
      err <= 1'b0;
    end else if (cap_en && ({c_out, result} != expected)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer -- accepts one {a, b, c_in} request, walks an external
// combinational ALU through ADD, SUB, XOR and AND (one mode per cycle) and
// presents the four results packed as {AND, XOR, SUB, ADD}, each nibble
// {c_out, result[2:0]}.
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready        : request handshake; in_a, in_b, in_c_in operands
//   alu_a/alu_b/alu_mode/alu_c_in : registered drive to the external ALU
//   alu_result/alu_c_out     : external ALU response
//   out_valid/out_ready      : result handshake; res_out packed results
//   err                      : sticky checker mismatch flag
// Optional feature: define ALU_SEQ_CHECK_EN to build the internal result
// checker (alu_seq_check); otherwise err is tied low.
//
// state    | meaning
// ST_IDLE  | waiting for a request (in_ready high once out of reset)
// ST_ISSUE | four cycles, alu_mode 0..3, capturing one nibble per cycle
// ST_DONE  | results held until out_valid && out_ready
module alu_sequencer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_a,
  input  logic [2:0]  in_b,
  input  logic        in_c_in,
  output logic [2:0]  alu_a,
  output logic [2:0]  alu_b,
  output logic [1:0]  alu_mode,
  output logic        alu_c_in,
  input  logic [2:0]  alu_result,
  input  logic        alu_c_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] res_out,
  output logic        err
);

  state_t state;

  // in_ready is a register rather than a decode of state so that it stays low
  // while reset is held and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      alu_a     <= 3'd0;
      alu_b     <= 3'd0;
      alu_mode  <= MODE_ADD;
      alu_c_in  <= 1'b0;
      res_out   <= 16'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            alu_a    <= in_a;
            alu_b    <= in_b;
            alu_c_in <= in_c_in;
            alu_mode <= MODE_ADD;
            in_ready <= 1'b0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          case (alu_mode)
            MODE_ADD: res_out[NIB_ADD +: NIB_W] <= {alu_c_out, alu_result};
            MODE_SUB: res_out[NIB_SUB +: NIB_W] <= {alu_c_out, alu_result};
            MODE_XOR: res_out[NIB_XOR +: NIB_W] <= {alu_c_out, alu_result};
            default:  res_out[NIB_AND +: NIB_W] <= {alu_c_out, alu_result};
          endcase
          if (alu_mode == MODE_AND) begin
            alu_mode <= MODE_ADD;
            state    <= ST_DONE;
          end else begin
            alu_mode <= alu_mode + 2'd1;
          end
        end
        ST_DONE: begin
          // out_valid is registered off DONE, so it rises one edge after the
          // final capture (the 5th edge after the accept edge).
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          alu_mode <= MODE_ADD;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic accept;
  logic cap_en;

  assign accept = (state == ST_IDLE) && in_valid && in_ready;
  assign cap_en = (state == ST_ISSUE);

  alu_seq_check u_check (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .cap_en (cap_en),
    .a      (alu_a),
    .b      (alu_b),
    .c_in   (alu_c_in),
    .mode   (alu_mode),
    .result (alu_result),
    .c_out  (alu_c_out),
    .err    (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_a;
  logic [2:0]  in_b;
  logic        in_c_in;
  logic [2:0]  alu_a;
  logic [2:0]  alu_b;
  logic [1:0]  alu_mode;
  logic        alu_c_in;
  logic [2:0]  alu_result;
  logic        alu_c_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res_out;
  logic        err;

  int checks = 0;
  int errors = 0;

`ifdef ALU_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // fault injection into the bench ALU
  logic       flt_en   = 1'b0;
  logic [1:0] flt_mode = 2'd0;
  logic       flt_flip = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c_in    (in_c_in),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_mode   (alu_mode),
    .alu_c_in   (alu_c_in),
    .alu_result (alu_result),
    .alu_c_out  (alu_c_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res_out    (res_out),
    .err        (err)
  );

  // behavioural meaning of each operation, as {c_out, result}
  function automatic logic [3:0] ref_nib(int a, int b, int c, int m);
    case (m)
      0:       return 4'((a + b + c) % 16);
      1:       return 4'((a - b + 8) % 16);
      2:       return 4'(a ^ b);
      default: return 4'(a & b);
    endcase
  endfunction

  function automatic logic [3:0] faulted(logic [3:0] n);
    return flt_flip ? (n ^ 4'd1) : (n | 4'd1);
  endfunction

  // external combinational ALU, with optional fault
  logic [3:0] alu_nib;
  always_comb begin
    alu_nib = ref_nib(int'(alu_a), int'(alu_b), int'(alu_c_in), int'(alu_mode));
    if (flt_en && alu_mode == flt_mode) alu_nib = faulted(alu_nib);
    alu_result = alu_nib[2:0];
    alu_c_out  = alu_nib[3];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected packed result including any injected fault
  task automatic model(input int a, input int b, input int c,
                       output logic [15:0] res, output logic e);
    logic [3:0] n;
    res = 16'd0;
    e   = 1'b0;
    for (int m = 0; m < 4; m++) begin
      n = ref_nib(a, b, c, m);
      if (flt_en && flt_mode == 2'(m)) n = faulted(n);
      if (n != ref_nib(a, b, c, m)) e = CHK;
      res[m*4 +: 4] = n;
    end
  endtask

  task automatic do_req(input logic [2:0] a, input logic [2:0] b, input logic c,
                        input logic [15:0] exp_res, input logic exp_err, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_c_in = c;
    step();
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_c_in = $urandom;
    chk("capture", {25'd0, alu_a, alu_b, alu_c_in}, {25'd0, a, b, c});
    chk("in_ready_issue", {31'd0, in_ready}, 32'd0);
    chk("err_cleared", {31'd0, err}, 32'd0);
    n = 0;
    while (!out_valid && n < 12) begin
      chk("alu_mode_seq", {30'd0, alu_mode}, (n < 4) ? n : 0);
      step();
      n++;
    end
    chk("out_valid_latency", n, 5);
    chk("res_out", {16'd0, res_out}, {16'd0, exp_res});
    chk("err", {31'd0, err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_stable", {14'd0, out_valid, in_ready, res_out}, {14'd0, 1'b1, 1'b0, exp_res});
      chk("hold_mode0", {30'd0, alu_mode}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_handshake", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic        c;
    logic [15:0] res;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[5];
    logic [15:0] er;
    logic        ee;
    int          a, b, c;

    tbl[0] = '{3'd3, 3'd2, 1'b0, 16'h2195};
    tbl[1] = '{3'd7, 3'd1, 1'b1, 16'h16E9};
    tbl[2] = '{3'd0, 3'd5, 1'b0, 16'h0535};
    tbl[3] = '{3'd7, 3'd7, 1'b1, 16'h708F};
    tbl[4] = '{3'd0, 3'd0, 1'b0, 16'h0080};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 3'd0; in_b = 3'd0; in_c_in = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_outputs", {22'd0, in_ready, out_valid, err, alu_mode, alu_c_in, res_out[0]},
        32'd0);
    chk("reset_res", {16'd0, res_out}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    step();
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 5; i++)
      do_req(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].res, 1'b0, (i == 1) ? 10 : 0);

    // reset during the 2nd ISSUE cycle
    step();
    in_valid = 1'b1; in_a = 3'd3; in_b = 3'd2; in_c_in = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_issue_mode", {30'd0, alu_mode}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctl", {21'd0, in_ready, out_valid, err, alu_mode, alu_a, alu_c_in},
        32'd0);
    chk("async_reset_b_res", {13'd0, alu_b, res_out}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("in_ready_held_low", {31'd0, in_ready}, 32'd0);
    step();
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    do_req(3'd3, 3'd2, 1'b0, 16'h2195, 1'b0, 1);

    // SUB result bit0 forced high: already 1 for 3-2, so no visible mismatch
    flt_en = 1'b1; flt_mode = 2'd1; flt_flip = 1'b0;
    do_req(3'd3, 3'd2, 1'b0, 16'h2195, 1'b0, 0);
    // SUB result bit0 flipped: mismatch, err sticky until the next accept
    flt_flip = 1'b1;
    do_req(3'd3, 3'd2, 1'b0, 16'h2185, CHK, 2);
    flt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_sticky_idle", {31'd0, err}, {31'd0, CHK});
    end
    do_req(3'd3, 3'd2, 1'b0, 16'h2195, 1'b0, 0);

    // randomized requests against the model
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 1));
      flt_en   = ($urandom_range(0, 9) == 0);
      flt_mode = 2'($urandom_range(0, 3));
      flt_flip = 1'($urandom_range(0, 1));
      model(a, b, c, er, ee);
      do_req(3'(a), 3'(b), 1'(c), er, ee, int'($urandom_range(0, 3)));
    end
    flt_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
